// File: rtl/fx_arb_pkg.sv
// fx_arb_pkg
//   Shared constants and types for the fx_add_arb saturating-adder arbiter.
//   DEF_WORD_LEN / DEF_NUM_REQ are the default parameter values used by
//   fx_add_arb. SAT_CNT_W is the width of the optional saturation counter,
//   which is built only when FX_ADD_ARB_SAT_CNT_EN is defined.
//   rsp_t is the packed response word {id, sum, sat} at the default widths.
//   It is used by logic that consumes or logs results from a default-sized
//   instance.
package fx_arb_pkg;

  localparam int DEF_WORD_LEN = 32;
  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_ID_W     = $clog2(DEF_NUM_REQ);
  localparam int SAT_CNT_W    = 16;

  typedef struct packed {
    logic [DEF_ID_W-1:0]     id;
    logic [DEF_WORD_LEN-1:0] sum;
    logic                    sat;
  } rsp_t;

endpackage : fx_arb_pkg

// File: rtl/fx_add_arb_rr_arb.sv
// rr_arb
//   Round-robin arbiter with a rotating priority pointer.
//   The grant goes to the first asserted request at or after the pointer,
//   searching in increasing index order and wrapping from NUM_REQ-1 to 0.
//   When the grant is consumed (take high while a grant exists), the pointer
//   moves to one past the granted index. Otherwise it holds.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, pointer -> 0
//   req        in   NUM_REQ request vector
//   take       in   grant is consumed this cycle
//   grant      out  one-hot grant (zero when no request)
//   grant_idx  out  index of the granted requester
//   grant_vld  out  at least one request is pending
module rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  logic [ID_W-1:0] ptr;
  logic [ID_W:0]   idx;

  // Search offsets 0..NUM_REQ-1 from the pointer. The index is one bit
  // wider so that the wrap works when NUM_REQ is not a power of two.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_vld && req[idx[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[ID_W-1:0];
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take && grant_vld) begin
      if (grant_idx == ID_W'(NUM_REQ-1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + ID_W'(1);
      end
    end
  end

endmodule : rr_arb

// File: rtl/fx_add_arb.sv
// fx_add_arb
//   A single saturating unsigned adder shared by NUM_REQ requesters through
//   round-robin arbitration. It has one register stage. A transfer in cycle
//   n makes the result visible in cycle n+1. A new result can be loaded
//   while the previous one drains, which gives one result per cycle.
//
//   Optional feature: define FX_ADD_ARB_SAT_CNT_EN to add the 16-bit sticky
//   saturation event counter and its sat_cnt port.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   per-requester operand pair valid
//   req_ready  out  per-requester accept (at most one bit high)
//   req_a      in   per-requester first operand
//   req_b      in   per-requester second operand
//   rsp_valid  out  result valid
//   rsp_ready  in   downstream accepts the result
//   rsp_id     out  requester that owns the result
//   rsp_sum    out  saturated sum
//   rsp_sat    out  result was clamped to all ones
//   sat_cnt    out  saturation event count (FX_ADD_ARB_SAT_CNT_EN only)
module fx_add_arb
  import fx_arb_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][WORD_LEN-1:0]  req_a,
  input  logic [NUM_REQ-1:0][WORD_LEN-1:0]  req_b,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [WORD_LEN-1:0]               rsp_sum,
  output logic                              rsp_sat
`ifdef FX_ADD_ARB_SAT_CNT_EN
  ,
  output logic [SAT_CNT_W-1:0]              sat_cnt
`endif
);

  logic               accept;
  logic               enable;
  logic               transfer;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_vld;
  logic [WORD_LEN-1:0] op_a;
  logic [WORD_LEN-1:0] op_b;
  logic [WORD_LEN:0]   sum_full;
  logic [WORD_LEN-1:0] sum_sat;
  logic                carry;

  // The output slot can take a new result when it is empty or is being
  // drained this cycle. Reset blocks every grant so that no transfer is
  // reported during a reset cycle.
  assign accept   = !rsp_valid || rsp_ready;
  assign enable   = accept && !rst;
  assign req_ready = enable ? grant : '0;
  assign transfer = enable && grant_vld;

  rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .take      (enable),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Operands are muxed by the granted index only. The grant never looks at
  // operand values, so req_ready has no operand dependency.
  assign op_a     = req_a[grant_idx];
  assign op_b     = req_b[grant_idx];
  assign sum_full = {1'b0, op_a} + {1'b0, op_b};
  assign carry    = sum_full[WORD_LEN];
  assign sum_sat  = carry ? '1 : sum_full[WORD_LEN-1:0];

  // The payload registers load only on a transfer, so they keep their last
  // values after a drain that has no new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_sat   <= 1'b0;
    end else if (transfer) begin
      rsp_valid <= 1'b1;
      rsp_id    <= grant_idx;
      rsp_sum   <= sum_sat;
      rsp_sat   <= carry;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef FX_ADD_ARB_SAT_CNT_EN
  // Sticky at all ones so that a long run never wraps back to a small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (transfer && carry && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + SAT_CNT_W'(1);
    end
  end
`endif

endmodule : fx_add_arb
